// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory slave for the memory stage.
// It accepts one load/store at a time over valid/ready, inserts WAIT_CYCLES
// wait states, then returns a single-cycle response strobe. Loads are sized
// and sign/zero extended; stores write byte lanes on the edge ending RESP.
//
// Handshake: a request is accepted on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE. resp_valid is high for
// exactly one cycle (RESP) per accepted request; resp_rdata and resp_err are
// only meaningful while resp_valid is 1 and read 0 otherwise.
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   - misaligned half/word and length=11 are rejected (resp_err=1,
//               resp_rdata=0, no store commit).
//   undefined - resp_err stays 0; half/word addresses are force-aligned,
//               length=11 behaves as word, and every store commits.
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_length,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              lat_we;
    logic              lat_sign;
    logic              lat_err;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [1:0]        lat_length;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_length;
    logic              acc_err;
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    // Upper address bits alias onto the decoded range and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W]};

    assign dbg_state = state;

    // Normalise the incoming request: either flag it as an error or force alignment.
    always_comb begin
        acc_addr   = req_addr[ADDR_W-1:0];
        acc_length = req_length;
        acc_err    = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        case (req_length)
            2'b01:   acc_err = req_addr[0];
            2'b10:   acc_err = |req_addr[1:0];
            2'b11:   acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
`else
        case (req_length)
            2'b01: acc_addr[0] = 1'b0;
            2'b10, 2'b11: begin
                acc_addr[1:0] = 2'b00;
                acc_length    = 2'b10;
            end
            default: acc_err = 1'b0;
        endcase
`endif
    end

    // Request FSM: IDLE accepts, WAIT counts wait states, RESP strobes the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_we     <= 1'b0;
            lat_sign   <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_length <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_sign   <= req_sign;
                        lat_err    <= acc_err;
                        lat_addr   <= acc_addr;
                        lat_wdata  <= req_wdata;
                        lat_length <= acc_length;
                        req_ready  <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        wait_cnt   <= '0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Byte-lane enables and lane-replicated store data for the latched request.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = lat_wdata;
        case (lat_length)
            2'b00: begin
                lane_en[lat_addr[1:0]] = 1'b1;
                lane_data              = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{lat_wdata[15:0]}};
            end
            default: lane_en = 4'b1111;
        endcase
    end

    // Store commit on the edge that ends RESP; a reset abort leaves state != RESP.
    always_ff @(posedge clk) begin
        if (state == RESP && lat_we && !lat_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[lat_addr[ADDR_W-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[lat_addr[ADDR_W-1:2]];

    // Combinational load path: pick the addressed byte/half and extend it.
    always_comb begin
        case (lat_addr[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (lat_length)
            2'b00:   load_data = {{24{lat_sign & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{lat_sign & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    assign resp_rdata = (resp_valid && !lat_we && !lat_err) ? load_data : 32'd0;
    assign resp_err   = resp_valid & lat_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan sequence with literal pins on
// the reference model, reset aborts, ready/valid cadence for WAIT_CYCLES 0
// and 3, full memory preload and randomized load/store traffic.
module tb_dmem_responder;

    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_length = 2'b00;
    logic        req_sign = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    logic        aux_valid = 1'b0;
    logic        w0_ready, w0_valid, w0_err;
    logic [31:0] w0_rdata;
    logic [1:0]  w0_state;
    logic        w3_ready, w3_valid, w3_err;
    logic [31:0] w3_rdata;
    logic [1:0]  w3_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];
    int          exp_cyc_q[$];

    logic [7:0]  mb [4096];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_length(req_length), .req_sign(req_sign), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .req_valid(aux_valid), .req_ready(w0_ready),
        .req_we(1'b1), .req_addr(32'h0000_03FC), .req_wdata(32'h0),
        .req_length(2'b10), .req_sign(1'b0), .resp_valid(w0_valid),
        .resp_rdata(w0_rdata), .resp_err(w0_err), .dbg_state(w0_state)
    );

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst), .req_valid(aux_valid), .req_ready(w3_ready),
        .req_we(1'b1), .req_addr(32'h0000_03FC), .req_wdata(32'h0),
        .req_length(2'b10), .req_sign(1'b0), .resp_valid(w3_valid),
        .resp_rdata(w3_rdata), .resp_err(w3_err), .dbg_state(w3_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, RISC-V sizing rules applied directly.
    function automatic void model_req(input bit we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [1:0] len,
                                      input bit sgn, output logic [31:0] rd, output bit err);
        int a;
        int n;
        logic [31:0] v;
        a   = int'(addr[11:0]);
        n   = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        err = 1'b0;
        rd  = 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
        if (len == 2'b11 || (a % n) != 0) err = 1'b1;
`else
        a = a - (a % n);
`endif
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mb[a + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a + i];
                if (sgn && n < 4 && v[8*n-1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                rd = v;
            end
        end
    endfunction

    // driver: present one request at a negedge, hold until accepted, then drain
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] len, input bit sgn, input bit expect_resp,
                         output logic [31:0] erd, output bit eerr);
        int n;
        erd  = 32'd0;
        eerr = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_length = len;
        req_sign   = sgn;
        if (expect_resp) begin
            model_req(we, addr, wdata, len, sgn, erd, eerr);
            exp_q.push_back(erd);
            exp_err_q.push_back(32'(eerr));
            exp_cyc_q.push_back(cyc + WAITC + 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (expect_resp) begin
            n = 0;
            while (exp_q.size() > 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    // scoreboard: compare every response strobe with the model's expectation
    always @(negedge clk) begin
        if (rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    chk("resp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                    chk("resp_rdata", resp_rdata, exp_q.pop_front());
                    chk("resp_err", 32'(resp_err), exp_err_q.pop_front());
                end
            end else if (exp_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                chk("resp_missing", 32'(resp_valid), 32'd1);
                void'(exp_q.pop_front());
                void'(exp_err_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] erd;
        bit          eerr;

        // reset: request input must be ignored and outputs held at reset values
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // back-to-back cadence with req_valid held high, WAIT_CYCLES 0 and 3
        @(negedge clk);
        aux_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("w0_ready", 32'(w0_ready), 32'(i % 2 == 0));
            chk("w0_valid", 32'(w0_valid), 32'(i % 2 == 1));
            chk("w3_ready", 32'(w3_ready), 32'(i % 5 == 0));
            chk("w3_valid", 32'(w3_valid), 32'(i % 5 == 4));
            if (w0_valid) chk("w0_store_rdata", w0_rdata | 32'(w0_err), 32'd0);
            if (w3_valid) chk("w3_store_rdata", w3_rdata | 32'(w3_err), 32'd0);
            @(negedge clk);
        end
        aux_valid = 1'b0;
        repeat (6) @(negedge clk);

        // directed sequence with literal expectations pinning the model
        issue(1'b1, 32'h010, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, erd, eerr);
        chk("lit_store_rdata", erd, 32'd0);
        issue(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1, erd, eerr);
        chk("lit_word_load", erd, 32'hDEADBEEF);
        issue(1'b1, 32'h013, 32'h00000080, 2'b00, 1'b0, 1'b1, erd, eerr);
        issue(1'b0, 32'h013, 32'h0, 2'b00, 1'b1, 1'b1, erd, eerr);
        chk("lit_lb_sign", erd, 32'hFFFFFF80);
        issue(1'b0, 32'h013, 32'h0, 2'b00, 1'b0, 1'b1, erd, eerr);
        chk("lit_lbu", erd, 32'h00000080);
        issue(1'b0, 32'h012, 32'h0, 2'b01, 1'b1, 1'b1, erd, eerr);
        chk("lit_lh_sign", erd, 32'hFFFF80AD);
        issue(1'b1, 32'h012, 32'h00001234, 2'b01, 1'b0, 1'b1, erd, eerr);
        issue(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1, erd, eerr);
        chk("lit_after_sh", erd, 32'h1234BEEF);
        issue(1'b0, 32'h010, 32'h0, 2'b00, 1'b0, 1'b1, erd, eerr);
        chk("lit_byte0", erd, 32'h000000EF);
        issue(1'b0, 32'h011, 32'h0, 2'b00, 1'b0, 1'b1, erd, eerr);
        chk("lit_byte1", erd, 32'h000000BE);
        issue(1'b1, 32'h011, 32'h55667788, 2'b10, 1'b0, 1'b1, erd, eerr);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("lit_misalign_err", 32'(eerr), 32'd1);
        issue(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1, erd, eerr);
        chk("lit_misalign_nowrite", erd, 32'h1234BEEF);
        issue(1'b0, 32'h010, 32'h0, 2'b11, 1'b0, 1'b1, erd, eerr);
        chk("lit_len11_err", 32'(eerr), 32'd1);
`else
        chk("lit_misalign_err", 32'(eerr), 32'd0);
        issue(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1, erd, eerr);
        chk("lit_misalign_write", erd, 32'h55667788);
        issue(1'b0, 32'h010, 32'h0, 2'b11, 1'b0, 1'b1, erd, eerr);
        chk("lit_len11_word", erd, 32'h55667788);
`endif

        // reset abort in WAIT and in RESP: no response, no commit
        issue(1'b1, 32'h020, 32'h11223344, 2'b10, 1'b0, 1'b1, erd, eerr);
        issue(1'b1, 32'h020, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, erd, eerr);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_wait_ready", 32'(req_ready), 32'd1);
        chk("abort_wait_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b1, 32'h020, 32'h99999999, 2'b10, 1'b0, 1'b0, erd, eerr);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_resp_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h020, 32'h0, 2'b10, 1'b0, 1'b1, erd, eerr);
        chk("lit_abort_nowrite", erd, 32'h11223344);

        // preload every word so random loads read defined data
        for (int i = 0; i < 1024; i++) begin
            issue(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 1'b1, erd, eerr);
        end

        // randomized traffic; full 32-bit addresses exercise aliasing
        for (int i = 0; i < 500; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, erd, eerr);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests issued by the processor's memory stage.
- Accepts one request at a time over a valid/ready handshake and holds word-organised storage with byte-lane writes.
- Applies RISC-V load sizing and sign extension, and returns read data after a configurable number of wait states.
- Replaces the zero-latency memory model so that the pipeline can be exercised against a realistic slave.

Parameters:
- ADDR_W, 12: byte-address bits decoded; DEPTH = 2**(ADDR_W-2) words; upper address bits are ignored (aliasing).
- WAIT_CYCLES, 1: wait states between request acceptance and response, range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_length  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign  in  1  1 = sign-extend load, 0 = zero-extend.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and for errors.
- resp_err  out  1  request rejected (misaligned or illegal length).

Behaviour:
- Reset:
  - rst low clears the FSM to IDLE, the wait counter to 0 and all latched request fields to 0.
  - Outputs during reset: resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
  - req_valid is ignored while rst is low.
  - Storage contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata/length/sign. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: req_ready=0. The counter increments each cycle. Go to RESP when counter == WAIT_CYCLES-1, and clear the counter.
  - RESP: req_ready=0. resp_valid=1 for exactly this cycle with resp_rdata and resp_err. Return to IDLE next cycle.
- Latency: acceptance edge to resp_valid high is WAIT_CYCLES+1 cycles. With back-to-back requests, minimum issue interval is WAIT_CYCLES+2 cycles.
- Error check (at acceptance, stored):
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - length=11 is an error.
- Store commit:
  - The array write happens on the clock edge ending the RESP cycle, only if no error. An errored store writes nothing.
  - Byte store: wdata[7:0] written to lane addr[1:0].
  - Half store: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - Word store: all 4 lanes written.
- Load data:
  - The word at addr[ADDR_W-1:2] is read during RESP, combinationally from the array.
  - The addressed byte or half is extracted and zero- or sign-extended to 32 bits per latched sign.
  - Word loads ignore sign.
- Reset mid-operation: asserting rst in WAIT or RESP aborts the request. No write commits and no resp_valid is produced.
- req_valid held high across a response: it is treated as a new request in the following IDLE cycle. The requester deasserts or changes it after the handshake.

Optional Feature:
- DMEM_MISALIGN_ERR_EN defined:
  - Alignment and length checking as above.
- DMEM_MISALIGN_ERR_EN undefined:
  - resp_err is tied 0.
  - Half requests force addr[0]=0 and word requests force addr[1:0]=00.
  - length=11 is treated as word.
  - All stores commit.

Test Plan:
- WAIT_CYCLES=1: word store 0xDEADBEEF @0x010, then word load @0x010 -> each resp_valid exactly 2 cycles after acceptance; load resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store 0x80 @0x013, then byte load sign=1 and sign=0 @0x013 -> 0xFFFFFF80 and 0x00000080; half load sign=1 @0x012 -> 0xFFFF80AD.
- Half store 0x1234 @0x012 over 0xDEADBEEF -> word load @0x010 returns 0x1234BEEF; bytes 0x010/0x011 are unchanged.
- With DMEM_MISALIGN_ERR_EN: word store @0x011 -> resp_err=1, resp_rdata=0; subsequent word load @0x010 is unchanged. Without the macro: same store writes @0x010, resp_err=0.
- WAIT_CYCLES=0 and 3: req_valid held high continuously -> req_ready pattern 1,0 and 1,0,0,0,0 respectively; issue interval 2 and 5 cycles.
- rst pulsed low during WAIT of a store 0xCAFEF00D @0x020 -> no resp_valid, req_ready=1 immediately; later load @0x020 returns the prior contents.
